// File: rtl/in_channel_queue.sv
// rtl/in_channel_queue.sv - multi-channel circular input queue serving the VM "in" and "inSize" instructions
module in_channel_queue #(
    parameter int MemoryElementWidth = 12,
    parameter int NIn                = 16,
    parameter int NChannels          = 4,
    localparam int CW = (NChannels > 1) ? $clog2(NChannels) : 1,
    localparam int SW = $clog2(NIn + 1),
    localparam int PW = $clog2(NIn)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          load_valid,
    input  logic [CW-1:0]                 load_channel,
    input  logic [MemoryElementWidth-1:0] load_data,
    output logic                          load_ready,
    input  logic                          cmd_valid,
    input  logic                          cmd_op,
    input  logic [CW-1:0]                 cmd_channel,
    output logic                          resp_valid,
    output logic [MemoryElementWidth-1:0] resp_data,
    output logic                          resp_empty,
    output logic [NChannels-1:0]          overflow
);

    logic [MemoryElementWidth-1:0] mem [NChannels][NIn];
    logic [PW-1:0]                 rd_ptr [NChannels];
    logic [PW-1:0]                 wr_ptr [NChannels];
    logic [SW-1:0]                 count  [NChannels];

    logic                          load_in_range, cmd_in_range;
    logic [CW-1:0]                 lch, cch;
    logic                          pop_ok, push;
    logic [NChannels-1:0]          push_ch, pop_ch, ovf_ch;
    logic [MemoryElementWidth-1:0] resp_data_d;
    logic                          resp_empty_d;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(NIn - 1)) ? '0 : p + PW'(1);
    endfunction

    // Out-of-range indices are folded to 0 for array access; the in-range flags gate every effect.
    always_comb begin
        load_in_range = int'(load_channel) < NChannels;
        cmd_in_range  = int'(cmd_channel) < NChannels;
        lch           = load_in_range ? load_channel : '0;
        cch           = cmd_in_range ? cmd_channel : '0;
        pop_ok        = cmd_valid && cmd_op && cmd_in_range && (count[cch] != '0);
        // A same-cycle pop on the addressed channel frees a slot even when full.
        load_ready    = load_in_range &&
                        ((count[lch] < SW'(NIn)) || (pop_ok && (cch == lch)));
        push          = load_valid && load_ready;
        for (int c = 0; c < NChannels; c++) begin
            push_ch[c] = push && (lch == CW'(c));
            pop_ch[c]  = pop_ok && (cch == CW'(c));
            ovf_ch[c]  = load_valid && load_in_range && !load_ready && (lch == CW'(c));
        end
    end

    always_comb begin
        resp_data_d  = '0;
        resp_empty_d = 1'b0;
        if (cmd_valid) begin
            if (!cmd_in_range) begin
                resp_empty_d = 1'b1;
            end else if (!cmd_op) begin
                resp_data_d = MemoryElementWidth'(count[cch]);
            end else if (count[cch] == '0) begin
                resp_empty_d = 1'b1;
            end else begin
                resp_data_d = mem[cch][rd_ptr[cch]];
            end
        end
    end

    // Storage carries no reset; pointers and counts define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[lch][wr_ptr[lch]] <= load_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NChannels; c++) begin
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                count[c]  <= '0;
            end
            overflow   <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_empty <= 1'b0;
        end else begin
            for (int c = 0; c < NChannels; c++) begin
                if (push_ch[c]) begin
                    wr_ptr[c] <= next_ptr(wr_ptr[c]);
                end
                if (pop_ch[c]) begin
                    rd_ptr[c] <= next_ptr(rd_ptr[c]);
                end
                if (push_ch[c] && !pop_ch[c]) begin
                    count[c] <= count[c] + SW'(1);
                end else if (pop_ch[c] && !push_ch[c]) begin
                    count[c] <= count[c] - SW'(1);
                end
                if (ovf_ch[c]) begin
                    overflow[c] <= 1'b1;
                end
            end
            resp_valid <= cmd_valid;
            resp_data  <= resp_data_d;
            resp_empty <= resp_empty_d;
        end
    end

endmodule

// File: tb/tb_in_channel_queue.sv
// tb/tb_in_channel_queue.sv - directed self-checking bench for in_channel_queue
module tb_in_channel_queue;

    localparam int W  = 12;
    localparam int N  = 16;
    localparam int NC = 4;
    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          load_valid;
    logic [CW-1:0] load_channel;
    logic [W-1:0]  load_data;
    logic          load_ready;
    logic          cmd_valid;
    logic          cmd_op;
    logic [CW-1:0] cmd_channel;
    logic          resp_valid;
    logic [W-1:0]  resp_data;
    logic          resp_empty;
    logic [NC-1:0] overflow;

    int checks = 0;
    int errors = 0;

    in_channel_queue #(
        .MemoryElementWidth(W),
        .NIn(N),
        .NChannels(NC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .load_valid(load_valid),
        .load_channel(load_channel),
        .load_data(load_data),
        .load_ready(load_ready),
        .cmd_valid(cmd_valid),
        .cmd_op(cmd_op),
        .cmd_channel(cmd_channel),
        .resp_valid(resp_valid),
        .resp_data(resp_data),
        .resp_empty(resp_empty),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic lv, input int lch, input int ld,
                         input logic cv, input logic cop, input int cch);
        load_valid   = lv;
        load_channel = CW'(lch);
        load_data    = W'(ld);
        cmd_valid    = cv;
        cmd_op       = cop;
        cmd_channel  = CW'(cch);
        step();
        load_valid = 1'b0;
        cmd_valid  = 1'b0;
    endtask

    task automatic resp_chk(input string tag, input int exp_data, input logic exp_empty);
        check({tag, ".valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".data"}, 32'(resp_data), 32'(exp_data));
        check({tag, ".empty"}, 32'(resp_empty), 32'(exp_empty));
    endtask

    task automatic cmd(input logic op, input int ch, input int exp_data,
                       input logic exp_empty, input string tag);
        drive(1'b0, 0, 0, 1'b1, op, ch);
        resp_chk(tag, exp_data, exp_empty);
    endtask

    initial begin
        reset = 1'b1;
        load_valid = 1'b0; load_channel = '0; load_data = '0;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_channel = '0;
        step(); step();
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_data", 32'(resp_data), 32'd0);
        check("rst.overflow", 32'(overflow), 32'd0);
        #1;
        check("rst.load_ready", 32'(load_ready), 32'd1);
        reset = 1'b0;
        step();

        cmd(1'b0, 0, 0, 1'b0, "size0_empty");
        step();
        check("resp_valid_drop", 32'(resp_valid), 32'd0);

        drive(1'b1, 0, 88, 1'b0, 1'b0, 0);
        drive(1'b1, 0, 44, 1'b0, 1'b0, 0);
        cmd(1'b0, 0, 2, 1'b0, "c0.size2");
        cmd(1'b1, 0, 88, 1'b0, "c0.pop88");
        cmd(1'b0, 0, 1, 1'b0, "c0.size1");
        cmd(1'b1, 0, 44, 1'b0, "c0.pop44");
        cmd(1'b0, 0, 0, 1'b0, "c0.size0");
        cmd(1'b1, 0, 0, 1'b1, "c0.pop_empty");

        for (int i = 1; i <= N; i++) drive(1'b1, 1, i, 1'b0, 1'b0, 0);
        load_channel = CW'(1);
        #1;
        check("c1.full_ready", 32'(load_ready), 32'd0);
        drive(1'b1, 1, 17, 1'b0, 1'b0, 0);
        check("c1.overflow", 32'(overflow), 32'b0010);
        cmd(1'b0, 1, 16, 1'b0, "c1.size16");
        for (int i = 1; i <= N; i++) cmd(1'b1, 1, i, 1'b0, $sformatf("c1.pop%0d", i));
        cmd(1'b1, 1, 0, 1'b1, "c1.pop_empty");

        for (int i = 0; i < N; i++) drive(1'b1, 2, 101 + i, 1'b0, 1'b0, 0);
        load_valid = 1'b1; load_channel = CW'(2); load_data = W'(99);
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_channel = CW'(2);
        #1;
        check("c2.ready_full_pop", 32'(load_ready), 32'd1);
        step();
        load_valid = 1'b0; cmd_valid = 1'b0;
        resp_chk("c2.pop_push", 101, 1'b0);
        cmd(1'b0, 2, 16, 1'b0, "c2.size16");
        for (int i = 1; i < N; i++) cmd(1'b1, 2, 101 + i, 1'b0, $sformatf("c2.pop%0d", 101 + i));
        cmd(1'b1, 2, 99, 1'b0, "c2.pop99");
        check("c2.no_overflow", 32'(overflow), 32'b0010);

        drive(1'b1, 3, 31, 1'b1, 1'b0, 0); resp_chk("il.size0_a", 0, 1'b0);
        drive(1'b1, 0, 7, 1'b1, 1'b1, 3);  resp_chk("il.pop31", 31, 1'b0);
        drive(1'b1, 3, 32, 1'b1, 1'b0, 0); resp_chk("il.size0_b", 1, 1'b0);
        drive(1'b1, 0, 8, 1'b1, 1'b1, 3);  resp_chk("il.pop32", 32, 1'b0);
        drive(1'b1, 3, 33, 1'b1, 1'b0, 3); resp_chk("il.size3_pre", 0, 1'b0);
        cmd(1'b1, 3, 33, 1'b0, "il.pop33");
        cmd(1'b0, 0, 2, 1'b0, "il.size0_c");
        cmd(1'b1, 0, 7, 1'b0, "il.pop7");
        cmd(1'b1, 0, 8, 1'b0, "il.pop8");

        drive(1'b1, 0, 55, 1'b1, 1'b1, 0); resp_chk("e.pop_nobypass", 0, 1'b1);
        cmd(1'b0, 0, 1, 1'b0, "e.size1");
        cmd(1'b1, 0, 55, 1'b0, "e.pop55");

        for (int i = 0; i < 5; i++) drive(1'b1, 1, 200 + i, 1'b0, 1'b0, 0);
        cmd(1'b0, 1, 5, 1'b0, "r.size5");
        reset = 1'b1;
        step();
        check("r.overflow_clr", 32'(overflow), 32'd0);
        reset = 1'b0;
        step();
        cmd(1'b0, 1, 0, 1'b0, "r.size0");
        check("r.overflow", 32'(overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
